// File: rtl/reg_dump_uart.sv
// Register-file dump engine: walks x0..x31 and streams each one out of an 8N1 UART
// as five bytes (index, then the 32-bit value MSB first).
module reg_dump_uart #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clockCPU,
   input  logic        reset,
   input  logic        iStart,
   output logic [4:0]  oRegSel,
   input  logic [31:0] iRegData,
   output logic        oTx,
   output logic        oBusy,
   output logic        oDone
);

   localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
   localparam logic [3:0]  BitLast  = 4'd9;
   localparam logic [2:0]  ByteLast = 3'd4;
   localparam logic [4:0]  RegLast  = 5'd31;

   typedef enum logic [2:0] {StIdle, StSelect, StLatch, StSend, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  index_q, index_d;
   logic [31:0] shadow_q, shadow_d;
   logic [15:0] baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [2:0]  byte_q, byte_d;
   logic        tx_q, tx_d;
   logic        start_q;
   logic        arm_q;
   logic        start_edge;
   logic [7:0]  tx_byte;
   logic [3:0]  data_idx;
   logic        frame_bit;

   // arm_q blocks an edge until iStart has been seen low after reset, so a line
   // already high when reset releases cannot start a dump.
   assign start_edge = iStart & ~start_q & arm_q;

   // Next-state logic: FSM, register index, shadow capture and bit/baud counters.
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      shadow_d = shadow_q;
      baud_d   = '0;
      bit_d    = '0;
      byte_d   = '0;
      case (state_q)
         StIdle: begin
            if (start_edge) begin
               index_d = '0;
               state_d = StSelect;
            end
         end
         StSelect: state_d = StLatch;
         StLatch: begin
            shadow_d = iRegData;
            state_d  = StSend;
         end
         StSend: begin
            baud_d = baud_q + 16'd1;
            bit_d  = bit_q;
            byte_d = byte_q;
            if (baud_q == BaudLast) begin
               baud_d = '0;
               if (bit_q == BitLast) begin
                  bit_d = '0;
                  if (byte_q == ByteLast) begin
                     byte_d = '0;
                     if (index_q == RegLast) begin
                        state_d = StDone;
                     end else begin
                        index_d = index_q + 5'd1;
                        state_d = StSelect;
                     end
                  end else begin
                     byte_d = byte_q + 3'd1;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Line level for the coming cycle, derived from next-state counters so oTx is a
   // clean register output aligned with the SEND state.
   always_comb begin
      tx_byte   = 8'h00;
      data_idx  = bit_d - 4'd1;
      frame_bit = 1'b1;
      case (byte_d)
         3'd0:    tx_byte = {3'b000, index_d};
         3'd1:    tx_byte = shadow_d[31:24];
         3'd2:    tx_byte = shadow_d[23:16];
         3'd3:    tx_byte = shadow_d[15:8];
         default: tx_byte = shadow_d[7:0];
      endcase
      if (bit_d == 4'd0) begin
         frame_bit = 1'b0;
      end else if (bit_d == BitLast) begin
         frame_bit = 1'b1;
      end else begin
         frame_bit = tx_byte[data_idx[2:0]];
      end
      tx_d = (state_d == StSend) ? frame_bit : 1'b1;
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clockCPU or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         index_q  <= '0;
         shadow_q <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         tx_q     <= 1'b1;
         start_q  <= 1'b0;
         arm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         shadow_q <= shadow_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         tx_q     <= tx_d;
         start_q  <= iStart;
         arm_q    <= arm_q | ~iStart;
      end
   end

   assign oRegSel = index_q;
   assign oTx     = tx_q;
   assign oBusy   = (state_q != StIdle);
   assign oDone   = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: register-file model, captured line trace, waveform and
// byte-level reference built from the frame arithmetic.
module tb_reg_dump_uart;

   localparam int C       = 4;
   localparam int RegCyc  = 2 + 50 * C;
   localparam int DumpCyc = 32 * RegCyc;

   logic        clockCPU = 1'b0;
   logic        reset;
   logic        iStart;
   logic [4:0]  oRegSel;
   logic [31:0] iRegData;
   logic        oTx;
   logic        oBusy;
   logic        oDone;

   logic [31:0] regs [32];
   logic        txs [$];
   logic [7:0]  rx [$];
   int          rx_pos [$];
   int          t_done, n_done, t_sel1;
   int          total = 0;
   int          bad = 0;

   reg_dump_uart #(.CLKS_PER_BIT(C)) dut (
      .clockCPU(clockCPU),
      .reset   (reset),
      .iStart  (iStart),
      .oRegSel (oRegSel),
      .iRegData(iRegData),
      .oTx     (oTx),
      .oBusy   (oBusy),
      .oDone   (oDone)
   );

   // Register file debug port; x0 reads as zero whatever the array holds.
   assign iRegData = (oRegSel == 5'd0) ? 32'h0 : regs[oRegSel];

   always #5 clockCPU = ~clockCPU;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int k);
      int r, b;
      logic [31:0] v;
      r = k / 5;
      b = k % 5;
      v = (r == 0) ? 32'h0 : regs[r];
      if (b == 0) return 8'(r);
      return 8'(v >> (8 * (4 - b)));
   endfunction

   // Expected line level c cycles after the first busy cycle.
   function automatic logic exp_tx(input int c);
      int r, o, b, k;
      logic [7:0] v;
      r = c / RegCyc;
      o = c % RegCyc;
      if (r >= 32 || o < 2) return 1'b1;
      o = o - 2;
      b = o / (10 * C);
      k = (o % (10 * C)) / C;
      v = exp_byte(r * 5 + b);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return v[k-1];
   endfunction

   // Runs one dump from the current cycle; iStart is dropped after the trigger and,
   // when repulse >= 0, raised again and held from that many cycles into the dump.
   task automatic capture(input int repulse);
      bit started = 0;
      int t0 = 0;
      txs.delete();
      t_done = -1;
      n_done = 0;
      t_sel1 = -1;
      for (int n = 0; n < DumpCyc + 200; n++) begin
         @(negedge clockCPU);
         if (!started && oBusy) begin
            started = 1;
            t0 = n;
         end
         if (started) begin
            if (!oBusy) break;
            txs.push_back(oTx);
            if (oDone) begin
               n_done++;
               t_done = n - t0;
            end
            if (oRegSel == 5'd1 && t_sel1 < 0) t_sel1 = n - t0;
         end
         if (n == 1) iStart = 1'b0;
         if (repulse >= 0 && started && (n - t0) == repulse) iStart = 1'b1;
      end
   endtask

   // Mid-bit UART decoder over the captured trace.
   task automatic decode();
      int i = 0;
      logic [7:0] v;
      rx.delete();
      rx_pos.delete();
      while (i < txs.size()) begin
         if (txs[i] == 1'b0 && i + 10 * C <= txs.size()) begin
            for (int k = 0; k < 8; k++) v[k] = txs[i + C * (k + 1) + C / 2];
            rx.push_back(v);
            rx_pos.push_back(i);
            i = i + 10 * C;
         end else begin
            i++;
         end
      end
   endtask

   task automatic check_dump(input string tag);
      int wave_bad = 0;
      int byte_bad = 0;
      int pos_bad = 0;
      check({tag, "_len"}, txs.size(), DumpCyc + 1);
      check({tag, "_done_at"}, t_done, DumpCyc);
      check({tag, "_done_cnt"}, n_done, 1);
      for (int c = 0; c < txs.size(); c++) if (txs[c] !== exp_tx(c)) wave_bad++;
      check({tag, "_wave_errs"}, wave_bad, 0);
      decode();
      check({tag, "_nbytes"}, rx.size(), 160);
      for (int k = 0; k < rx.size() && k < 160; k++) begin
         if (rx[k] !== exp_byte(k)) byte_bad++;
         if (rx_pos[k] != 2 + (k / 5) * RegCyc + (k % 5) * 10 * C) pos_bad++;
      end
      check({tag, "_byte_errs"}, byte_bad, 0);
      check({tag, "_pos_errs"}, pos_bad, 0);
      check({tag, "_sel1_at"}, t_sel1, RegCyc);
   endtask

   task automatic rand_regs();
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
   endtask

   initial begin
      int busy_cnt, lows, highs;
      logic [7:0] b;

      // Reset with iStart held high, then no dump for 100 cycles.
      reset  = 1'b0;
      iStart = 1'b1;
      for (int r = 0; r < 32; r++) regs[r] = 32'h0;
      #2 reset = 1'b1;
      #1;
      check("rst_tx", oTx, 1'b1);
      check("rst_busy", oBusy, 1'b0);
      check("rst_done", oDone, 1'b0);
      check("rst_sel", oRegSel, 5'd0);
      repeat (2) @(negedge clockCPU);
      reset = 1'b0;
      busy_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clockCPU);
         if (oBusy || !oTx) busy_cnt++;
      end
      check("no_start_after_rst", busy_cnt, 0);
      iStart = 1'b0;
      repeat (3) @(negedge clockCPU);

      // x5 = DEADBEEF, everything else zero (x0 non-zero in the array, reads as zero).
      regs[0] = 32'h1234_5678;
      regs[5] = 32'hDEAD_BEEF;
      iStart = 1'b1;
      capture(-1);
      check_dump("dumpA");
      for (int k = 0; k < 5; k++) begin
         b = (k < rx.size()) ? rx[k] : 8'hxx;
         check($sformatf("dumpA_x0_byte%0d", k), b, 8'h00);
      end
      check("dumpA_b25", (rx.size() > 25) ? rx[25] : 8'hxx, 8'h05);
      check("dumpA_b26", (rx.size() > 26) ? rx[26] : 8'hxx, 8'hDE);
      check("dumpA_b27", (rx.size() > 27) ? rx[27] : 8'hxx, 8'hAD);
      check("dumpA_b28", (rx.size() > 28) ? rx[28] : 8'hxx, 8'hBE);
      check("dumpA_b29", (rx.size() > 29) ? rx[29] : 8'hxx, 8'hEF);
      lows = 0;
      highs = 0;
      if (txs.size() > 42) begin
         for (int c = 2; c < 38; c++) if (txs[c] == 1'b0) lows++;
         for (int c = 38; c < 42; c++) if (txs[c] == 1'b1) highs++;
         check("dumpA_idle_before", {txs[0], txs[1]}, 2'b11);
      end
      check("dumpA_first_low", lows, 36);
      check("dumpA_first_stop", highs, 4);
      repeat (5) @(negedge clockCPU);

      // Random registers, x31 all ones; retrigger at cycle 1000 and hold through DONE.
      rand_regs();
      regs[31] = 32'hFFFF_FFFF;
      iStart = 1'b1;
      capture(1000);
      check_dump("dumpB");
      for (int k = 0; k < 5; k++) begin
         b = (rx.size() == 160) ? rx[155 + k] : 8'hxx;
         check($sformatf("dumpB_last_byte%0d", k), b, (k == 0) ? 8'h1F : 8'hFF);
      end
      busy_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clockCPU);
         if (oBusy || oDone) busy_cnt++;
      end
      check("dumpB_no_restart", busy_cnt, 0);
      iStart = 1'b0;
      repeat (3) @(negedge clockCPU);

      // Reset during the start bit of the x10 index byte, then a clean restart.
      rand_regs();
      iStart = 1'b1;
      @(negedge clockCPU);
      iStart = 1'b0;
      check("dumpC_busy", oBusy, 1'b1);
      repeat (10 * RegCyc + 3) @(negedge clockCPU);
      check("dumpC_sel_x10", oRegSel, 5'd10);
      check("dumpC_pre_low", oTx, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("dumpC_async_tx", oTx, 1'b1);
      check("dumpC_async_busy", oBusy, 1'b0);
      check("dumpC_async_sel", oRegSel, 5'd0);
      repeat (2) @(negedge clockCPU);
      reset = 1'b0;
      repeat (3) @(negedge clockCPU);
      check("dumpC_idle_after", oBusy, 1'b0);
      rand_regs();
      iStart = 1'b1;
      capture(-1);
      check_dump("dumpC");
      check("dumpC_restart_x0", (rx.size() > 0) ? rx[0] : 8'hxx, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
